// File: rtl/wb_port_arbiter_if.sv
// Writeback port arbiter bus bundle.
// Groups the EXE and LSU writeback handshakes, the register-file write port,
// the issue-side scoreboard update and the decode hazard query.
//   master : pipeline side (drives requests, issue and decode queries)
//   slave  : arbiter side (returns ready, write port and hazard)
interface wb_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             exe_valid;
  logic [4:0]       exe_rd;
  logic [WIDTH-1:0] exe_data;
  logic             exe_ready;

  logic             lsu_valid;
  logic [4:0]       lsu_rd;
  logic [WIDTH-1:0] lsu_data;
  logic             lsu_ready;

  logic             reg_write;
  logic [4:0]       waddr;
  logic [WIDTH-1:0] wdata;

  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       chk_rs1;
  logic [4:0]       chk_rs2;
  logic             hazard;

  modport master (
    output exe_valid, exe_rd, exe_data,
    input  exe_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  reg_write, waddr, wdata,
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  hazard
  );

  modport slave (
    input  exe_valid, exe_rd, exe_data,
    output exe_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output reg_write, waddr, wdata,
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    output hazard
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter.
// Shares the single register-file write port between EXE and LSU writeback
// requesters. LSU wins ties unless EXE has lost STARVE_LIMIT ties in a row.
// The winning write is registered onto reg_write/waddr/wdata one cycle after
// the handshake. A pending-write scoreboard lets decode detect RAW hazards.
// Ports:
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : wb_port_arbiter_if.slave (handshakes, write port, scoreboard)
module wb_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset_n,
  wb_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [5:0] DEPTH_W    = 6'(DEPTH);

  // True for a register that exists and is not the hardwired-zero x0.
  function automatic logic is_real_reg(input logic [4:0] rd);
    return (rd != 5'd0) && ({1'b0, rd} < DEPTH_W);
  endfunction

  // Scoreboard lookup; x0 and out-of-range indices are never pending.
  function automatic logic lookup_pending(input logic [4:0] rs,
                                          input logic [DEPTH-1:0] pend);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      hit = hit | (pend[i] & (rs == 5'(i)));
    end
    return hit;
  endfunction

  logic [3:0]       starve_cnt_r;
  logic [3:0]       starve_nxt_s;
  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pending_nxt_s;
  logic             reg_write_r;
  logic [4:0]       waddr_r;
  logic [WIDTH-1:0] wdata_r;

  logic             starve_hit_s;
  logic             grant_exe_s;
  logic             grant_lsu_s;
  logic             grant_any_s;
  logic [4:0]       grant_rd_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             write_s;

  assign starve_hit_s = (starve_cnt_r == STARVE_MAX);
  assign grant_any_s  = grant_exe_s | grant_lsu_s;
  assign write_s      = grant_any_s & is_real_reg(grant_rd_s);

  // Arbitration: single requester wins; tie goes to LSU unless EXE is starved.
  always_comb begin
    grant_exe_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (bus.exe_valid && (!bus.lsu_valid || starve_hit_s)) begin
      grant_exe_s = 1'b1;
      grant_lsu_s = 1'b0;
    end else if (bus.lsu_valid) begin
      grant_exe_s = 1'b0;
      grant_lsu_s = 1'b1;
    end else begin
      grant_exe_s = 1'b0;
      grant_lsu_s = 1'b0;
    end
  end

  // Payload of the granted requester.
  always_comb begin
    grant_rd_s   = 5'd0;
    grant_data_s = '0;
    if (grant_exe_s) begin
      grant_rd_s   = bus.exe_rd;
      grant_data_s = bus.exe_data;
    end else begin
      grant_rd_s   = bus.lsu_rd;
      grant_data_s = bus.lsu_data;
    end
  end

  // Starvation counter: counts EXE losses, saturating at the limit.
  always_comb begin
    starve_nxt_s = 4'd0;
    if (bus.exe_valid && grant_lsu_s) begin
      if (starve_cnt_r < STARVE_MAX) begin
        starve_nxt_s = starve_cnt_r + 4'd1;
      end else begin
        starve_nxt_s = starve_cnt_r;
      end
    end else begin
      starve_nxt_s = 4'd0;
    end
  end

  // Scoreboard update: set is applied after clear so a same-edge issue wins.
  always_comb begin
    pending_nxt_s    = pending_r;
    pending_nxt_s[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      pending_nxt_s[i] = (bus.issue_valid && (bus.issue_rd == 5'(i))) |
                         (pending_r[i] & ~(write_s && (grant_rd_s == 5'(i))));
    end
  end

  // State registers and the registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= 4'd0;
      pending_r    <= '0;
      reg_write_r  <= 1'b0;
      waddr_r      <= 5'd0;
      wdata_r      <= '0;
    end else begin
      starve_cnt_r <= starve_nxt_s;
      pending_r    <= pending_nxt_s;
      reg_write_r  <= write_s;
      if (write_s) begin
        waddr_r <= grant_rd_s;
        wdata_r <= grant_data_s;
      end
    end
  end

  assign bus.exe_ready = grant_exe_s;
  assign bus.lsu_ready = grant_lsu_s;
  assign bus.reg_write = reg_write_r;
  assign bus.waddr     = waddr_r;
  assign bus.wdata     = wdata_r;
  assign bus.hazard    = lookup_pending(bus.chk_rs1, pending_r) |
                         lookup_pending(bus.chk_rs2, pending_r);

endmodule
